// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
//
// Forwarding source codes, stage bit indices and FSM state encodings used by
// pipeline_hazard_ctrl and fwd_select.
package pipeline_hazard_ctrl_pkg;

    // Operand forwarding source selects
    localparam logic [1:0] FWD_REG      = 2'd0;
    localparam logic [1:0] FWD_EXE_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
    localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

    // Bit positions inside stage_en / stage_rst
    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    // Load-use stall FSM
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LSTALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// rtl/pipeline_hazard_ctrl_fwd_select.sv - one operand's forwarding match and priority logic
//
// Ports:
//   src_addr_i                source register read by the ID instruction
//   exe_addr_i/exe_wen_i      destination and write enable of the EXE instruction
//   exe_is_load_i             EXE instruction is a load
//   mem_addr_i/mem_wen_i      destination and write enable of the MEM instruction
//   mem_is_load_i             MEM instruction is a load
//   sel_o                     forwarding source code (FWD_*)
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] exe_addr_i,
    input  logic              exe_wen_i,
    input  logic              exe_is_load_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_wen_i,
    input  logic              mem_is_load_i,
    output logic [1:0]        sel_o
);

    logic exe_hit;
    logic mem_hit;

    // Register 0 is hard-wired zero, so it never matches.
    assign exe_hit = exe_wen_i && (exe_addr_i != '0) && (exe_addr_i == src_addr_i);
    assign mem_hit = mem_wen_i && (mem_addr_i != '0) && (mem_addr_i == src_addr_i);

    always_comb begin
        sel_o = FWD_REG;
        if (exe_hit) begin
            // A load in EXE has no data yet; the load-use stall covers this
            // case, and the older MEM value must not shadow the newer write.
            sel_o = exe_is_load_i ? FWD_REG : FWD_EXE_ALU;
        end else if (mem_hit) begin
            sel_o = mem_is_load_i ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding and stage-control unit for the 5-stage pipeline
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   id_rs_addr/id_rt_addr           ID source registers, with id_rs_used/id_rt_used
//   id_is_store, id_branch_taken    ID instruction is a store / branch resolved taken
//   exe_*/mem_*                     destination, write enable and load flag of EXE / MEM
//   mem_req, mem_ack                data-memory request / completion (freeze while pending)
//   debug_en, debug_step            debug halt enable and single-step request level
//   fwd_a_ctrl, fwd_b_ctrl, fwd_m   operand and store-data forwarding selects
//   stage_en, stage_rst             per-stage enable and bubble, bit 0 IF .. bit 4 WB
//   stall_cycles                    saturating count of load-stall and freeze cycles
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int DELAY_SLOT = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     id_rs_addr,
    input  logic [ADDR_W-1:0]     id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_is_store,
    input  logic                  id_branch_taken,
    input  logic [ADDR_W-1:0]     exe_regw_addr,
    input  logic [ADDR_W-1:0]     mem_regw_addr,
    input  logic                  exe_wb_wen,
    input  logic                  mem_wb_wen,
    input  logic                  exe_is_load,
    input  logic                  mem_is_load,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    input  logic                  debug_en,
    input  logic                  debug_step,
    output logic [1:0]            fwd_a_ctrl,
    output logic [1:0]            fwd_b_ctrl,
    output logic                  fwd_m,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [CNT_W-1:0]      stall_cycles
);

    // First LSTALL cycle follows the detect cycle, so the remaining count
    // starts two below the bubble count.
    localparam logic [2:0] CNT_INIT = 3'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    hz_state_e        state_q;
    logic [2:0]       cnt_q;
    logic             debug_step_prev_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       freeze;
    logic       step_edge;
    logic       dbg_halt;
    logic       advance;
    logic       rs_hit;
    logic       rt_hit;
    logic       hz;
    logic       stall_act;
    logic       fwd_m_raw;

    fwd_select #(.ADDR_W(ADDR_W)) u_fwd_a (
        .src_addr_i    (id_rs_addr),
        .exe_addr_i    (exe_regw_addr),
        .exe_wen_i     (exe_wb_wen),
        .exe_is_load_i (exe_is_load),
        .mem_addr_i    (mem_regw_addr),
        .mem_wen_i     (mem_wb_wen),
        .mem_is_load_i (mem_is_load),
        .sel_o         (fwd_a_sel)
    );

    fwd_select #(.ADDR_W(ADDR_W)) u_fwd_b (
        .src_addr_i    (id_rt_addr),
        .exe_addr_i    (exe_regw_addr),
        .exe_wen_i     (exe_wb_wen),
        .exe_is_load_i (exe_is_load),
        .mem_addr_i    (mem_regw_addr),
        .mem_wen_i     (mem_wb_wen),
        .mem_is_load_i (mem_is_load),
        .sel_o         (fwd_b_sel)
    );

    assign freeze    = mem_req & ~mem_ack;
    assign step_edge = debug_step & ~debug_step_prev_q;
    assign dbg_halt  = debug_en & ~step_edge;
    assign advance   = ~freeze & ~dbg_halt;

    // Store data (rt) of a SW can take the load result late in MEM, so an
    // rt match on a store is handled by fwd_m instead of a stall.
    assign rs_hit = id_rs_used & (id_rs_addr == exe_regw_addr);
    assign rt_hit = id_rt_used & ~id_is_store & (id_rt_addr == exe_regw_addr);
    assign hz     = exe_is_load & exe_wb_wen & (exe_regw_addr != '0) & (rs_hit | rt_hit);

    assign fwd_m_raw = id_is_store & id_rt_used & exe_is_load & exe_wb_wen
                     & (exe_regw_addr == id_rt_addr) & (id_rt_addr != '0);

    assign stall_act = advance & (((state_q == ST_RUN) & hz) | (state_q == ST_LSTALL));

    assign stall_cycles_d = ((stall_act | freeze) && (stall_cycles_q != '1))
                          ? stall_cycles_q + 1'b1 : stall_cycles_q;

    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (!rst) begin
            stage_rst = '1;
        end else if (!advance) begin
            // Freeze and debug halt hold every stage without inserting bubbles.
            stage_en = '0;
        end else if (stall_act) begin
            stage_en[STG_IF]  = 1'b0;
            stage_en[STG_ID]  = 1'b0;
            stage_rst[STG_EX] = 1'b1;
        end else if (id_branch_taken && (DELAY_SLOT == 0)) begin
            stage_rst[STG_ID] = 1'b1;
        end
    end

    assign fwd_a_ctrl   = rst ? fwd_a_sel : FWD_REG;
    assign fwd_b_ctrl   = rst ? fwd_b_sel : FWD_REG;
    assign fwd_m        = rst & fwd_m_raw;
    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= ST_RUN;
            cnt_q             <= '0;
            debug_step_prev_q <= 1'b0;
            stall_cycles_q    <= '0;
        end else begin
            debug_step_prev_q <= debug_step;
            stall_cycles_q    <= stall_cycles_d;
            if (advance) begin
                case (state_q)
                    ST_RUN: begin
                        if (hz && (LOAD_LAT > 1)) begin
                            state_q <= ST_LSTALL;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                    ST_LSTALL: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_RUN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, exe_regw_addr, mem_regw_addr;
    logic       id_rs_used, id_rt_used, id_is_store, id_branch_taken;
    logic       exe_wb_wen, mem_wb_wen, exe_is_load, mem_is_load;
    logic       mem_req, mem_ack, debug_en, debug_step;

    logic [1:0]  a_fwd_a, a_fwd_b, d_fwd_a, d_fwd_b, s_fwd_a, s_fwd_b;
    logic        a_fwd_m, d_fwd_m, s_fwd_m;
    logic [4:0]  a_en, a_rst, d_en, d_rst, s_en, s_rst;
    logic [15:0] a_cnt, d_cnt;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .DELAY_SLOT(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
        .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr),
        .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen),
        .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .debug_en(debug_en), .debug_step(debug_step),
        .fwd_a_ctrl(a_fwd_a), .fwd_b_ctrl(a_fwd_b), .fwd_m(a_fwd_m),
        .stage_en(a_en), .stage_rst(a_rst), .stall_cycles(a_cnt)
    );

    pipeline_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .DELAY_SLOT(1), .CNT_W(16)) u_ds (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
        .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr),
        .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen),
        .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .debug_en(debug_en), .debug_step(debug_step),
        .fwd_a_ctrl(d_fwd_a), .fwd_b_ctrl(d_fwd_b), .fwd_m(d_fwd_m),
        .stage_en(d_en), .stage_rst(d_rst), .stall_cycles(d_cnt)
    );

    pipeline_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .DELAY_SLOT(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
        .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr),
        .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen),
        .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .debug_en(debug_en), .debug_step(debug_step),
        .fwd_a_ctrl(s_fwd_a), .fwd_b_ctrl(s_fwd_b), .fwd_m(s_fwd_m),
        .stage_en(s_en), .stage_rst(s_rst), .stall_cycles(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_is_store = 1'b0; id_branch_taken = 1'b0;
        exe_regw_addr = 5'd0; mem_regw_addr = 5'd0;
        exe_wb_wen = 1'b0; mem_wb_wen = 1'b0; exe_is_load = 1'b0; mem_is_load = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic exe_bubble();
        exe_regw_addr = 5'd0; exe_wb_wen = 1'b0; exe_is_load = 1'b0;
    endtask

    initial begin
        idle();
        debug_en = 1'b0; debug_step = 1'b0;
        rst = 1'b0;
        // A live forwarding match must stay masked while in reset.
        exe_regw_addr = 5'd3; exe_wb_wen = 1'b1; id_rs_addr = 5'd3; id_rs_used = 1'b1;
        cyc(); #1;
        chk("rst_en",   a_en,    5'h1f);
        chk("rst_rst",  a_rst,   5'h1f);
        chk("rst_fwda", a_fwd_a, 2'd0);
        chk("rst_cnt",  a_cnt,   16'd0);

        rst = 1'b1;
        cyc(); #1;
        // add $3 in EXE, ID reads $3
        chk("exe_fwd_a", a_fwd_a, 2'd1);
        chk("exe_en",    a_en,    5'h1f);
        chk("exe_rst",   a_rst,   5'h00);
        chk("exe_fwd_b", a_fwd_b, 2'd0);

        // lw $3 in MEM
        exe_bubble(); mem_regw_addr = 5'd3; mem_wb_wen = 1'b1; mem_is_load = 1'b1;
        id_rt_addr = 5'd3; id_rt_used = 1'b1;
        #1;
        chk("memld_fwd_a", a_fwd_a, 2'd3);
        chk("memld_fwd_b", a_fwd_b, 2'd3);
        // MEM ALU result, then EXE priority over MEM
        mem_is_load = 1'b0;
        #1;
        chk("memalu_fwd_a", a_fwd_a, 2'd2);
        exe_regw_addr = 5'd3; exe_wb_wen = 1'b1;
        #1;
        chk("prio_fwd_a", a_fwd_a, 2'd1);
        // writes to $0 are never forwarded
        idle();
        exe_wb_wen = 1'b1; mem_wb_wen = 1'b1; id_rs_used = 1'b1;
        #1;
        chk("zero_fwd_a", a_fwd_a, 2'd0);

        // lw $4 in EXE, add reads $4 as rs: three stall cycles
        cyc();
        idle();
        exe_regw_addr = 5'd4; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
        id_rs_addr = 5'd4; id_rs_used = 1'b1;
        #1;
        chk("ldu_en0",  a_en,  5'b11100);
        chk("ldu_rst0", a_rst, 5'b00100);
        cyc();
        exe_bubble();
        for (int i = 1; i < 3; i++) begin
            #1;
            chk($sformatf("ldu_en%0d", i),  a_en,  5'b11100);
            chk($sformatf("ldu_rst%0d", i), a_rst, 5'b00100);
            cyc();
        end
        #1;
        chk("ldu_done_en", a_en,  5'h1f);
        chk("ldu_cnt",     a_cnt, 16'd3);
        chk("ldu_sat_cnt", s_cnt, 2'd3);

        // lw $5 in EXE, sw $5 as data: forward, no stall
        cyc();
        idle();
        exe_regw_addr = 5'd5; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
        id_is_store = 1'b1; id_rt_addr = 5'd5; id_rt_used = 1'b1;
        id_rs_addr = 5'd1; id_rs_used = 1'b1;
        #1;
        chk("fwdm",    a_fwd_m, 1'b1);
        chk("fwdm_en", a_en,    5'h1f);
        // sw with rs = $5 (address) stalls
        id_rs_addr = 5'd5;
        #1;
        chk("sw_rs_en", a_en, 5'b11100);

        // Now in LSTALL with cnt = 1: freeze for 4 cycles
        cyc();
        exe_bubble(); id_is_store = 1'b0; id_rt_used = 1'b0;
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("frz_en%0d", i),  a_en,  5'b00000);
            chk($sformatf("frz_rst%0d", i), a_rst, 5'b00000);
            cyc();
        end
        mem_req = 1'b0;
        #1;
        chk("frz_post_en0", a_en, 5'b11100);
        cyc(); #1;
        chk("frz_post_en1", a_en, 5'b11100);
        cyc(); #1;
        chk("frz_done_en", a_en,  5'h1f);
        chk("frz_cnt",     a_cnt, 16'd10);
        chk("frz_sat_cnt", s_cnt, 2'd3);

        // Taken branch, no hazard
        cyc();
        idle();
        id_branch_taken = 1'b1;
        #1;
        chk("br_rst",    a_rst, 5'b00010);
        chk("br_en",     a_en,  5'h1f);
        chk("br_ds_rst", d_rst, 5'b00000);
        cyc();
        id_branch_taken = 1'b0;
        #1;
        chk("br_after_rst", a_rst, 5'b00000);
        // Taken branch with simultaneous load-use hazard
        exe_regw_addr = 5'd6; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
        id_rt_addr = 5'd6; id_rt_used = 1'b1; id_branch_taken = 1'b1;
        #1;
        chk("brhz_rst0", a_rst, 5'b00100);
        cyc();
        exe_bubble();
        #1;
        chk("brhz_rst1", a_rst, 5'b00100);
        cyc(); cyc();
        idle();

        // Debug halt with step held high
        debug_step = 1'b1;
        cyc();
        debug_en = 1'b1;
        #1;
        chk("dbg_hold_en0", a_en, 5'b00000);
        cyc();
        id_branch_taken = 1'b1;
        #1;
        chk("dbg_hold_en1",  a_en,  5'b00000);
        chk("dbg_hold_rst1", a_rst, 5'b00000);
        cyc();
        debug_step = 1'b0;
        #1;
        chk("dbg_low_en", a_en, 5'b00000);
        cyc();
        debug_step = 1'b1;
        #1;
        chk("dbg_step_en",  a_en,  5'h1f);
        chk("dbg_step_rst", a_rst, 5'b00010);
        cyc(); #1;
        chk("dbg_rehalt_en", a_en, 5'b00000);
        cyc();
        debug_en = 1'b0; debug_step = 1'b0;
        idle();

        // Reset in the middle of a load stall
        exe_regw_addr = 5'd7; exe_wb_wen = 1'b1; exe_is_load = 1'b1;
        id_rs_addr = 5'd7; id_rs_used = 1'b1;
        #1;
        chk("rsthz_en", a_en, 5'b11100);
        cyc();
        exe_bubble();
        rst = 1'b0;
        #1;
        chk("rstmid_en",  a_en,  5'h1f);
        chk("rstmid_rst", a_rst, 5'h1f);
        cyc();
        rst = 1'b1;
        #1;
        chk("rstpost_en",  a_en,  5'h1f);
        chk("rstpost_rst", a_rst, 5'b00000);
        chk("rstpost_cnt", a_cnt, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
